dm_abstract_cmd_ctrl: RTL and testbench
=======================================

Name: dm_abstract_cmd_ctrl

Overview:
- Sequences Debug Module abstract commands of the Access Register type, per RISC-V debug spec 0.13.
- Accepts a debugger write to the command register and validates it. Runs a req/ack transfer with the halted hart and moves data through abstract data 0.
- Maintains busy and cmderr for the abstractcs register.
- Sits between the DM register decode (DMI side) and the hart's debug register-access port.

Parameters:
- ADDR_W, 8, DM register address width; kept for decode consistency, unused internally.
- TIMEOUT, 255, maximum cycles to wait for hart_ack before aborting (must be ≥1).

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  one-cycle pulse: DMI write to command register (0x17)
- cmd_data  input  32  command word written
- data0_wr  input  1  one-cycle pulse: DMI write to data0 (0x04)
- data0_wdata  input  32  value written to data0
- data0  output  32  current abstract data 0 contents
- cmderr_clr  input  3  W1C mask from abstractcs write, qualified by cmderr_clr_valid
- cmderr_clr_valid  input  1  abstractcs write strobe
- busy  output  1  abstractcs.busy
- cmderr  output  3  abstractcs.cmderr
- hart_halted  input  1  selected hart is halted
- hart_req  output  1  register access request, held until ack
- hart_we  output  1  1 = write hart register, 0 = read
- hart_regno  output  16  hart register number
- hart_wdata  output  32  write data (equals data0)
- hart_ack  input  1  one-cycle completion pulse from hart
- hart_rdata  input  32  read data, valid with hart_ack
- hart_err  input  1  access faulted, valid with hart_ack

Behaviour:
- Reset (async, rst=1): state=IDLE; data0=0; cmderr=0; busy=0; hart_req=0; hart_we=0; hart_regno=0; timeout counter=0.
- Command fields: cmdtype[31:24], aarsize[22:20], postincrement[19], transfer[17], write[16], regno[15:0].
- States are IDLE, REQ and DONE. busy = (state != IDLE). hart_req = (state == REQ). All outputs are registered or decoded from state only.
- IDLE, on cmd_valid, checks in priority order:
  1. cmderr != 0: command ignored, no state change.
  2. cmdtype != 0 or aarsize != 2: cmderr <= 2 (not supported), stay IDLE.
  3. hart_halted == 0: cmderr <= 4 (halt/resume), stay IDLE.
  4. transfer == 0: go to DONE (busy one cycle), no hart access.
  5. Otherwise: latch regno and write into hart_regno/hart_we, clear counter, go to REQ.
- REQ: hart_req=1 and hart_wdata=data0. hart_regno and hart_we stay stable until ack.
  - On hart_ack with hart_err=1: cmderr <= 3 (exception), data0 unchanged, go to DONE.
  - On hart_ack with hart_err=0: if hart_we=0, data0 <= hart_rdata; go to DONE.
  - Counter increments each cycle without ack. When it reaches TIMEOUT: cmderr <= 7 (other), go to DONE. A later stray ack is ignored.
- DONE: if postincrement was set, hart_regno <= hart_regno + 1, modulo 2^16 (0xFFFF wraps to 0x0000). Always go to IDLE next cycle.
- Latency: cmd_valid sampled at edge k gives busy=1 and hart_req=1 after edge k. Ack sampled at edge m gives DONE after m and busy=0 after m+1. Minimum command with immediate ack: busy high for 2 cycles.
- While busy:
  - cmd_valid: command dropped; cmderr <= 1 if cmderr == 0.
  - data0_wr: write dropped; cmderr <= 1 if cmderr == 0.
- data0_wr in IDLE: data0 <= data0_wdata.
- A data0_wr in the same cycle as an accepted cmd_valid takes effect first. The transfer then uses the new data0.
- cmderr clear: on cmderr_clr_valid, cmderr <= cmderr & ~cmderr_clr. If an error set occurs in the same cycle, the set wins.
- Reset mid-operation: any state returns to IDLE immediately; hart_req drops asynchronously.

Test Plan:
- Halted hart, data0_wr 0xDEADBEEF, cmd 0x00231008 (write, transfer, aarsize=2, regno 0x1008), ack after 3 cycles -> hart_req high 4 cycles with hart_we=1, hart_regno=0x1008, hart_wdata=0xDEADBEEF; busy drops 2 cycles after ack; cmderr=0.
- Read: cmd 0x002A1001 (postincrement), ack with hart_rdata 0x12345678 -> data0=0x12345678, hart_regno=0x1002 after DONE; command with regno 0xFFFF and postincrement -> hart_regno=0x0000.
- cmd_valid and data0_wr during REQ -> cmderr=1, data0 unchanged; further cmd ignored; cmderr_clr=3'b111 -> cmderr=0; next cmd accepted.
- cmdtype=1 -> cmderr=2, busy never asserted. aarsize=3 -> cmderr=2. hart_halted=0 with a valid cmd -> cmderr=4, no hart_req.
- hart_err=1 on ack -> cmderr=3, data0 unchanged. No ack with TIMEOUT=8 -> hart_req drops after 8 cycles, cmderr=7.
- rst pulse while in REQ -> hart_req=0 and busy=0 immediately, data0=0, cmderr=0; next valid command completes normally.

Source files
------------

// File: rtl/dm_abstract_cmd_ctrl.sv
// Abstract command sequencer for Access Register commands: validates the
// command word, runs one req/ack register access with the halted hart and
// keeps data0 plus the abstractcs busy/cmderr fields.
module dm_abstract_cmd_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_data,
    input  logic        data0_wr,
    input  logic [31:0] data0_wdata,
    output logic [31:0] data0,
    input  logic [2:0]  cmderr_clr,
    input  logic        cmderr_clr_valid,
    output logic        busy,
    output logic [2:0]  cmderr,
    input  logic        hart_halted,
    output logic        hart_req,
    output logic        hart_we,
    output logic [15:0] hart_regno,
    output logic [31:0] hart_wdata,
    input  logic        hart_ack,
    input  logic [31:0] hart_rdata,
    input  logic        hart_err
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unused_addr_w = ADDR_W;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_BUSY    = 3'd1;
    localparam logic [2:0] ERR_NOTSUP  = 3'd2;
    localparam logic [2:0] ERR_EXCEPT  = 3'd3;
    localparam logic [2:0] ERR_HALTRES = 3'd4;
    localparam logic [2:0] ERR_OTHER   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        data0_q, data0_d;
    logic [2:0]         cmderr_q, cmderr_d;
    logic [15:0]        regno_q, regno_d;
    logic               we_q, we_d;
    logic               postinc_q, postinc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;

    logic [7:0]         cmd_type;
    logic [2:0]         cmd_aarsize;
    logic               cmd_postinc;
    logic               cmd_transfer;
    logic               cmd_write;
    logic [15:0]        cmd_regno;
    logic               unused_cmd_bits;

    assign cmd_type        = cmd_data[31:24];
    assign cmd_aarsize     = cmd_data[22:20];
    assign cmd_postinc     = cmd_data[19];
    assign cmd_transfer    = cmd_data[17];
    assign cmd_write       = cmd_data[16];
    assign cmd_regno       = cmd_data[15:0];
    assign unused_cmd_bits = ^{cmd_data[23], cmd_data[18]};

    assign cnt_inc = cnt_q + CNT_W'(1);

    assign busy       = (state_q != S_IDLE);
    assign hart_req   = (state_q == S_REQ);
    assign hart_we    = we_q;
    assign hart_regno = regno_q;
    assign hart_wdata = data0_q;
    assign data0      = data0_q;
    assign cmderr     = cmderr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            data0_q   <= '0;
            cmderr_q  <= ERR_NONE;
            regno_q   <= '0;
            we_q      <= 1'b0;
            postinc_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            data0_q   <= data0_d;
            cmderr_q  <= cmderr_d;
            regno_q   <= regno_d;
            we_q      <= we_d;
            postinc_q <= postinc_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data0_d   = data0_q;
        cmderr_d  = cmderr_q;
        regno_d   = regno_q;
        we_d      = we_q;
        postinc_d = postinc_q;
        cnt_d     = cnt_q;

        // Clear is applied first so that any error raised below overrides it.
        if (cmderr_clr_valid) begin
            cmderr_d = cmderr_q & ~cmderr_clr;
        end

        if (state_q != S_IDLE && (cmd_valid || data0_wr) && cmderr_q == ERR_NONE) begin
            cmderr_d = ERR_BUSY;
        end

        case (state_q)
            S_IDLE: begin
                if (data0_wr) begin
                    data0_d = data0_wdata;
                end
                if (cmd_valid && cmderr_q == ERR_NONE) begin
                    if (cmd_type != 8'd0 || cmd_aarsize != 3'd2) begin
                        cmderr_d = ERR_NOTSUP;
                    end else if (!hart_halted) begin
                        cmderr_d = ERR_HALTRES;
                    end else if (!cmd_transfer) begin
                        // No register was selected, so there is nothing to post-increment.
                        postinc_d = 1'b0;
                        state_d   = S_DONE;
                    end else begin
                        regno_d   = cmd_regno;
                        we_d      = cmd_write;
                        postinc_d = cmd_postinc;
                        cnt_d     = '0;
                        state_d   = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (hart_ack) begin
                    if (hart_err) begin
                        cmderr_d = ERR_EXCEPT;
                    end else if (!we_q) begin
                        data0_d = hart_rdata;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT)) begin
                        cmderr_d = ERR_OTHER;
                        state_d  = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (postinc_q) begin
                    regno_d = regno_q + 16'd1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_dm_abstract_cmd_ctrl.sv
// Bench for dm_abstract_cmd_ctrl: directed scenarios plus randomized commands,
// checked against a transaction-level model of data0, cmderr and regno.
module tb_dm_abstract_cmd_ctrl;
    localparam int TB_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        data0_wr;
    logic [31:0] data0_wdata;
    logic [31:0] data0;
    logic [2:0]  cmderr_clr;
    logic        cmderr_clr_valid;
    logic        busy;
    logic [2:0]  cmderr;
    logic        hart_halted;
    logic        hart_req;
    logic        hart_we;
    logic [15:0] hart_regno;
    logic [31:0] hart_wdata;
    logic        hart_ack;
    logic [31:0] hart_rdata;
    logic        hart_err;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] m_data0;
    logic [2:0]  m_cmderr;
    logic [15:0] m_regno;

    dm_abstract_cmd_ctrl #(.ADDR_W(8), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .data0_wr(data0_wr), .data0_wdata(data0_wdata), .data0(data0),
        .cmderr_clr(cmderr_clr), .cmderr_clr_valid(cmderr_clr_valid),
        .busy(busy), .cmderr(cmderr),
        .hart_halted(hart_halted), .hart_req(hart_req), .hart_we(hart_we),
        .hart_regno(hart_regno), .hart_wdata(hart_wdata),
        .hart_ack(hart_ack), .hart_rdata(hart_rdata), .hart_err(hart_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one command and act as the hart; delay = cycles of hart_req before ack.
    task automatic run_cmd(input logic [31:0] cmd, input int delay, input logic [31:0] rdata,
                           input bit err, input int poke, input bit wr, input logic [31:0] wval,
                           input string tag);
        int kind;
        int req_cycles;
        int exp_cycles;
        bit acked;
        logic [15:0] reg_in;
        reg_in = cmd[15:0];
        if (wr) m_data0 = wval;
        kind = 0;
        if (m_cmderr != 3'd0) kind = 0;
        else if (cmd[31:24] != 8'd0 || cmd[22:20] != 3'd2) m_cmderr = 3'd2;
        else if (!hart_halted) m_cmderr = 3'd4;
        else if (!cmd[17]) kind = 1;
        else kind = 2;

        cmd_valid = 1'b1; cmd_data = cmd; data0_wr = wr; data0_wdata = wval;
        tick();
        cmd_valid = 1'b0; data0_wr = 1'b0;

        if (kind == 2) begin
            n_total++;
            if ({busy, hart_req, hart_we, hart_regno, hart_wdata} !== {2'b11, cmd[16], reg_in, m_data0})
                $display("FAIL %s start busy/req/we/regno/wdata got=%b/%b/%b/%h/%h exp=1/1/%b/%h/%h",
                         tag, busy, hart_req, hart_we, hart_regno, hart_wdata, cmd[16], reg_in, m_data0);
            else n_pass++;
            req_cycles = 0;
            acked = 1'b0;
            for (int c = 0; c < 64 && hart_req; c++) begin
                req_cycles++;
                n_total++;
                if ({hart_we, hart_regno} !== {cmd[16], reg_in})
                    $display("FAIL %s stable we/regno got=%b/%h exp=%b/%h", tag, hart_we, hart_regno, cmd[16], reg_in);
                else n_pass++;
                if (c == poke) begin
                    cmd_valid = 1'b1; cmd_data = $urandom; data0_wr = 1'b1; data0_wdata = $urandom;
                    if (m_cmderr == 3'd0) m_cmderr = 3'd1;
                end
                if (c == delay) begin
                    hart_ack = 1'b1; hart_rdata = rdata; hart_err = err; acked = 1'b1;
                end
                tick();
                cmd_valid = 1'b0; data0_wr = 1'b0; hart_ack = 1'b0; hart_err = 1'b0; hart_rdata = $urandom;
            end
            exp_cycles = (delay < TB_TIMEOUT) ? delay + 1 : TB_TIMEOUT;
            n_total++;
            if (req_cycles != exp_cycles)
                $display("FAIL %s req_cycles got=%0d exp=%0d", tag, req_cycles, exp_cycles);
            else n_pass++;
            if (acked) begin
                if (err) m_cmderr = 3'd3;
                else if (!cmd[16]) m_data0 = rdata;
            end else begin
                m_cmderr = 3'd7;
            end
            m_regno = cmd[19] ? reg_in + 16'd1 : reg_in;
            n_total++;
            if ({busy, hart_req} !== 2'b10)
                $display("FAIL %s done busy/req got=%b%b exp=10", tag, busy, hart_req);
            else n_pass++;
            tick();
        end else if (kind == 1) begin
            n_total++;
            if ({busy, hart_req} !== 2'b10)
                $display("FAIL %s notransfer busy/req got=%b%b exp=10", tag, busy, hart_req);
            else n_pass++;
            tick();
        end

        n_total++;
        if ({busy, hart_req, cmderr, data0, hart_regno} !== {2'b00, m_cmderr, m_data0, m_regno})
            $display("FAIL %s end busy/req/cmderr/data0/regno got=%b%b/%0d/%h/%h exp=00/%0d/%h/%h",
                     tag, busy, hart_req, cmderr, data0, hart_regno, m_cmderr, m_data0, m_regno);
        else n_pass++;
    endtask

    task automatic write_data0(input logic [31:0] val);
        data0_wr = 1'b1; data0_wdata = val;
        tick();
        data0_wr = 1'b0;
        m_data0 = val;
        n_total++;
        if (data0 !== m_data0) $display("FAIL data0_write got=%h exp=%h", data0, m_data0);
        else n_pass++;
    endtask

    task automatic clear_err(input logic [2:0] mask);
        cmderr_clr_valid = 1'b1; cmderr_clr = mask;
        tick();
        cmderr_clr_valid = 1'b0;
        m_cmderr = m_cmderr & ~mask;
        n_total++;
        if (cmderr !== m_cmderr) $display("FAIL cmderr_clear got=%0d exp=%0d", cmderr, m_cmderr);
        else n_pass++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(); tick();
        n_total++;
        if ({busy, hart_req, hart_we, cmderr, data0, hart_regno} !== '0)
            $display("FAIL reset_held busy/req/we/cmderr/data0/regno got=%b%b%b/%0d/%h/%h exp=000/0/0/0",
                     busy, hart_req, hart_we, cmderr, data0, hart_regno);
        else n_pass++;
        rst = 1'b0;
        tick();
        m_data0 = '0; m_cmderr = '0; m_regno = '0;
        n_total++;
        if ({busy, hart_req, cmderr, data0} !== '0)
            $display("FAIL reset_release busy/req/cmderr/data0 got=%b%b/%0d/%h exp=00/0/0", busy, hart_req, cmderr, data0);
        else n_pass++;
    endtask

    task automatic test_write_cmd;
        hart_halted = 1'b1;
        write_data0(32'hDEADBEEF);
        run_cmd(32'h00231008, 3, 32'h0, 1'b0, -1, 1'b0, 32'h0, "write_cmd");
    endtask

    task automatic test_read_postinc;
        run_cmd(32'h002A1001, 1, 32'h12345678, 1'b0, -1, 1'b0, 32'h0, "read_postinc");
        run_cmd(32'h002AFFFF, 0, 32'hCAFEF00D, 1'b0, -1, 1'b0, 32'h0, "postinc_wrap");
    endtask

    task automatic test_busy_errors;
        write_data0(32'hA5A5_0001);
        run_cmd(32'h00230300, 4, 32'h0, 1'b0, 1, 1'b0, 32'h0, "busy_poke");
        run_cmd(32'h00220301, 0, 32'h1, 1'b0, -1, 1'b0, 32'h0, "ignored_cmd");
        clear_err(3'b111);
        run_cmd(32'h00220302, 2, 32'h7777_0000, 1'b0, -1, 1'b0, 32'h0, "after_clear");
    endtask

    task automatic test_unsupported;
        run_cmd(32'h01220000, 0, 32'h0, 1'b0, -1, 1'b0, 32'h0, "cmdtype1");
        clear_err(3'b010);
        run_cmd(32'h00320000, 0, 32'h0, 1'b0, -1, 1'b0, 32'h0, "aarsize3");
        clear_err(3'b111);
        hart_halted = 1'b0;
        run_cmd(32'h00221000, 0, 32'h0, 1'b0, -1, 1'b0, 32'h0, "not_halted");
        hart_halted = 1'b1;
        clear_err(3'b100);
        run_cmd(32'h00200005, 0, 32'h0, 1'b0, -1, 1'b0, 32'h0, "no_transfer");
        run_cmd(32'h00231234, 1, 32'h0, 1'b0, -1, 1'b1, 32'h0BAD_CAFE, "wr_with_cmd");
    endtask

    task automatic test_err_timeout;
        run_cmd(32'h00220010, 2, 32'hFFFF_FFFF, 1'b1, -1, 1'b0, 32'h0, "hart_err");
        clear_err(3'b111);
        run_cmd(32'h00220011, 20, 32'h0, 1'b0, -1, 1'b0, 32'h0, "timeout");
        hart_ack = 1'b1; hart_rdata = 32'h5555_AAAA;
        tick();
        hart_ack = 1'b0;
        n_total++;
        if ({busy, cmderr, data0} !== {1'b0, m_cmderr, m_data0})
            $display("FAIL stray_ack busy/cmderr/data0 got=%b/%0d/%h exp=0/%0d/%h", busy, cmderr, data0, m_cmderr, m_data0);
        else n_pass++;
        clear_err(3'b111);
    endtask

    task automatic test_reset_mid;
        write_data0(32'h1357_9BDF);
        cmd_valid = 1'b1; cmd_data = 32'h00234321;
        tick();
        cmd_valid = 1'b1; cmd_data = 32'h00230000;
        tick();
        cmd_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({busy, hart_req, cmderr, data0, hart_regno} !== '0)
            $display("FAIL reset_mid busy/req/cmderr/data0/regno got=%b%b/%0d/%h/%h exp=00/0/0/0",
                     busy, hart_req, cmderr, data0, hart_regno);
        else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        m_data0 = '0; m_cmderr = '0; m_regno = '0;
        run_cmd(32'h00220042, 1, 32'h2468_ACE0, 1'b0, -1, 1'b0, 32'h0, "after_reset");
    endtask

    task automatic test_random;
        logic [31:0] cmd;
        int delay;
        int poke;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) clear_err(3'($urandom));
            if ($urandom_range(0, 4) == 0) write_data0($urandom);
            hart_halted = ($urandom_range(0, 7) != 0);
            cmd = '0;
            cmd[31:24] = ($urandom_range(0, 9) == 0) ? 8'd1 : 8'd0;
            cmd[22:20] = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'd2;
            cmd[19]    = 1'($urandom);
            cmd[17]    = ($urandom_range(0, 9) != 0);
            cmd[16]    = 1'($urandom);
            cmd[15:0]  = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
            delay = $urandom_range(0, 10);
            poke  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, (delay < TB_TIMEOUT) ? delay : TB_TIMEOUT - 1) : -1;
            run_cmd(cmd, delay, $urandom, ($urandom_range(0, 6) == 0), poke,
                    ($urandom_range(0, 4) == 0), $urandom, "random");
        end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; data0_wr = 1'b0; data0_wdata = '0;
        cmderr_clr = '0; cmderr_clr_valid = 1'b0; hart_halted = 1'b1;
        hart_ack = 1'b0; hart_rdata = '0; hart_err = 1'b0;
        m_data0 = '0; m_cmderr = '0; m_regno = '0;
        test_reset();
        test_write_cmd();
        test_read_postinc();
        test_busy_errors();
        test_unsupported();
        test_err_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
